dadda_mul16_seq: RTL and testbench
==================================

Name: dadda_mul16_seq

Overview:
Sequential 16x16 unsigned multiplier built on one shared 8x8 Dadda multiplier instance. It splits each operand into bytes and feeds the four byte-pair products through the single combinational multiplier, one per step. A shift-add accumulator combines the products. Valid/ready handshakes on both sides let it sit between a requester and a result consumer in the arithmetic datapath.

Parameters:
MUL_PIPE, 0, register stages after the 8x8 multiplier output. Legal values are 0 or 1. With 1, issue and accumulate are offset by one cycle.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  16  multiplicand, unsigned
b  input  16  multiplier, unsigned
out_valid  output  1  product valid (high only in DONE)
out_ready  input  1  consumer accepts product
p  output  32  product a*b, unsigned
busy  output  1  high in MUL or DONE

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE, step=0, acc=0, p=0, out_valid=0, busy=0. in_ready=1 because it is decoded from IDLE.
- FSM states are IDLE, MUL and DONE.
  - IDLE to MUL on in_valid && in_ready. a and b are captured into operand registers and acc is cleared.
  - MUL runs steps 0..3 on a 2-bit counter, one issue per cycle.
  - After the last accumulate, MUL goes to DONE.
  - DONE to IDLE on out_ready.
- Step schedule:
  - step0: a[7:0]*b[7:0], shift 0
  - step1: a[15:8]*b[7:0], shift 8
  - step2: a[7:0]*b[15:8], shift 8
  - step3: a[15:8]*b[15:8], shift 16
- Width rules:
  - Each 16-bit step product is zero-extended, shifted, and added into the 32-bit acc.
  - The sum never exceeds 2^32-1, so there is no carry-out. Dropping bit 32 is legal.
- MUL_PIPE=1: the multiplier output is registered. Step k is accumulated in the cycle after it is issued. The FSM leaves MUL after the last accumulate, not the last issue.
- Latency from the in handshake edge to out_valid=1 is 5+MUL_PIPE cycles. p is driven from acc.
- Backpressure: in DONE with out_ready=0, p and out_valid hold stable indefinitely. in_ready stays 0 and in_valid is ignored.
- Throughput: in_ready reasserts in the IDLE cycle after the out handshake. Minimum spacing between accepts is 6+MUL_PIPE cycles.
- a and b are sampled only on the in handshake. Changes to them during MUL/DONE have no effect.
- Reset mid-operation aborts immediately to the reset values above. No partial product is ever presented.
- in_valid asserted during MUL/DONE is not accepted. The requester must hold it until in_ready.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined:
  - If a==0 or b==0 at the in handshake, the FSM goes IDLE to DONE directly with acc=0.
  - out_valid=1 one cycle after the handshake, and the multiplier is not stepped.
  - Non-zero operands behave exactly as in the base block.
- Undefined: zero operands take the full 5+MUL_PIPE latency, with the same result 0.

Decomposition:
- Package dadda_seq_pkg holds:
  - state enum (IDLE/MUL/DONE)
  - NUM_STEPS=4
  - the per-step shift table {0,8,8,16}
  - the per-step byte-select table
- The only sub-module is the existing 8x8 Dadda multiplier, instantiated once. The operand byte mux, accumulator and FSM stay in this module.

Test Plan:
1. a=0x1234, b=0x5678, out_ready=1, MUL_PIPE=0 -> p=0x06260060, out_valid exactly 5 cycles after the handshake, high for 1 cycle.
2. a=0xFFFF, b=0xFFFF -> p=0xFFFE0001. Repeat with MUL_PIPE=1 -> same p, latency 6.
3. a=0x00FF, b=0x0100 with out_ready held 0 for 10 cycles -> p=0x0000FF00 stable and out_valid=1 throughout. in_ready=0, and a new in_valid with a=0x0002 is not accepted. Release -> IDLE next cycle.
4. Start a=0xAAAA, b=0x5555, drive rst_n low during step 2 -> out_valid=0, p=0, in_ready=1 while in reset. After release, a=3, b=5 -> p=15.
5. a=0x0000, b=0xABCD -> p=0. Latency 5 without MUL_ZERO_SKIP_EN, 1 with it.
6. Back-to-back ops with in_valid and out_ready tied 1 (0x0002*0x0003, then 0x8000*0x0002) -> p=0x00000006 then 0x00010000, accepts spaced exactly 6 cycles apart.

Source files
------------

// File: rtl/dadda_seq_pkg.sv
// Shared types and step tables for the sequential 16x16 Dadda multiplier.
package dadda_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_STEPS = 4;

    // Left shift applied to each byte-pair product before accumulation.
    localparam logic [4:0] STEP_SHIFT [NUM_STEPS] = '{5'd0, 5'd8, 5'd8, 5'd16};

    // Byte select per step: bit0 picks the high byte of a, bit1 the high byte of b.
    localparam logic [1:0] STEP_SEL [NUM_STEPS] = '{2'b00, 2'b01, 2'b10, 2'b11};

endpackage

// File: rtl/dadda_mul16_seq_if.sv
// Request/response handshake bundle between requester and multiplier.
interface dadda_mul16_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );

endinterface

// File: rtl/dadda_mul16_seq_dadda8.sv
// Combinational 8x8 unsigned Dadda multiplier.
// Partial products are compressed column by column to heights 6, 4, 3, 2,
// then the two remaining rows are summed by one carry-propagate adder.
module dadda_mul16_seq_dadda8 (
    input  logic [7:0]  i_x,
    input  logic [7:0]  i_y,
    output logic [15:0] o_p
);

    localparam int DADDA_D [4] = '{6, 4, 3, 2};

    // Bit-level Dadda reduction; the tree shape depends only on constants.
    always_comb begin
        logic [15:0] cur   [16];
        logic [15:0] nxt   [16];
        int          cur_h [16];
        int          nxt_h [16];
        int          k;
        int          tot;
        logic        s_bit;
        logic        c_bit;
        logic [15:0] row0;
        logic [15:0] row1;

        // NOTE: every variable gets a value before any conditional use so no latch is inferred.
        s_bit = 1'b0;
        c_bit = 1'b0;
        k     = 0;
        tot   = 0;
        row0  = '0;
        row1  = '0;
        for (int c = 0; c < 16; c++) begin
            cur[c]   = '0;
            nxt[c]   = '0;
            cur_h[c] = 0;
            nxt_h[c] = 0;
        end

        // Partial-product matrix, one bit per (i, j) dropped into column i+j.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cur[i+j][4'(cur_h[i+j])] = i_x[i] & i_y[j];
                cur_h[i+j]++;
            end
        end

        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 16; c++) begin
                nxt[c]   = '0;
                nxt_h[c] = 0;
            end
            for (int c = 0; c < 16; c++) begin
                k = 0;
                // Carries arriving from column c-1 count toward this column's target height.
                for (int it = 0; it < 4; it++) begin
                    tot = (cur_h[c] - k) + nxt_h[c];
                    if (tot > DADDA_D[s] && (cur_h[c] - k) >= 2) begin
                        if (tot == DADDA_D[s] + 1) begin
                            s_bit = cur[c][4'(k)] ^ cur[c][4'(k+1)];
                            c_bit = cur[c][4'(k)] & cur[c][4'(k+1)];
                            k     = k + 2;
                        end else begin
                            s_bit = cur[c][4'(k)] ^ cur[c][4'(k+1)] ^ cur[c][4'(k+2)];
                            c_bit = (cur[c][4'(k)] & cur[c][4'(k+1)]) |
                                    (cur[c][4'(k)] & cur[c][4'(k+2)]) |
                                    (cur[c][4'(k+1)] & cur[c][4'(k+2)]);
                            k     = k + 3;
                        end
                        nxt[c][4'(nxt_h[c])] = s_bit;
                        nxt_h[c]++;
                        if (c < 15) begin
                            nxt[c+1][4'(nxt_h[c+1])] = c_bit;
                            nxt_h[c+1]++;
                        end
                    end
                end
                // Bits not consumed by an adder pass straight through.
                for (int r = 0; r < 16; r++) begin
                    if (r >= k && r < cur_h[c]) begin
                        nxt[c][4'(nxt_h[c])] = cur[c][r];
                        nxt_h[c]++;
                    end
                end
            end
            for (int c = 0; c < 16; c++) begin
                cur[c]   = nxt[c];
                cur_h[c] = nxt_h[c];
            end
        end

        for (int c = 0; c < 16; c++) begin
            row0[c] = cur[c][0];
            row1[c] = cur[c][1];
        end
        o_p = row0 + row1;
    end

endmodule

// File: rtl/dadda_mul16_seq.sv
// Sequential 16x16 unsigned multiplier: four byte-pair products issued through
// one shared 8x8 Dadda multiplier and combined by a shift-add accumulator.
// MUL_PIPE=1 registers the 8x8 product, delaying each accumulate by a cycle.
// Optional feature macro MUL_ZERO_SKIP_EN: a zero operand jumps straight to DONE.
module dadda_mul16_seq
    import dadda_seq_pkg::*;
#(
    parameter int MUL_PIPE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    dadda_mul16_seq_if.slave  bus
);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_step;
    logic        r_issue_done;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [31:0] r_acc;

    logic        w_accept;
    logic        w_zero;
    logic        w_issue;
    logic [1:0]  w_sel;
    logic [7:0]  w_mx_a;
    logic [7:0]  w_mx_b;
    logic [15:0] w_prod;
    logic        w_acc_en;
    logic [1:0]  w_acc_step;
    logic [15:0] w_acc_prod;
    logic        w_last_acc;

    assign w_accept = bus.in_valid && (r_state == IDLE);
`ifdef MUL_ZERO_SKIP_EN
    assign w_zero   = (bus.a == 16'd0) || (bus.b == 16'd0);
`else
    assign w_zero   = 1'b0;
`endif

    // Issue one byte pair per MUL cycle until all four are in flight.
    assign w_issue = (r_state == MUL) && !r_issue_done;
    assign w_sel   = STEP_SEL[r_step];
    assign w_mx_a  = w_sel[0] ? r_a[15:8] : r_a[7:0];
    assign w_mx_b  = w_sel[1] ? r_b[15:8] : r_b[7:0];

    dadda_mul16_seq_dadda8 u_dadda8 (
        .i_x (w_mx_a),
        .i_y (w_mx_b),
        .o_p (w_prod)
    );

    generate
        if (MUL_PIPE == 1) begin : g_pipe
            logic        r_pv;
            logic [1:0]  r_pstep;
            logic [15:0] r_pprod;

            // Product register: the accumulate for step k happens one cycle after its issue.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv    <= 1'b0;
                    r_pstep <= 2'd0;
                    r_pprod <= 16'd0;
                end else begin
                    r_pv    <= w_issue;
                    r_pstep <= r_step;
                    r_pprod <= w_prod;
                end
            end

            assign w_acc_en   = r_pv;
            assign w_acc_step = r_pstep;
            assign w_acc_prod = r_pprod;
        end else begin : g_comb
            assign w_acc_en   = w_issue;
            assign w_acc_step = r_step;
            assign w_acc_prod = w_prod;
        end
    endgenerate

    assign w_last_acc = w_acc_en && (w_acc_step == 2'd3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_zero ? DONE : MUL;
            MUL:     if (w_last_acc) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        bus.busy      = (r_state == MUL) || (r_state == DONE);
    end

    // Operand capture, step counter and shift-add accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= 16'd0;
            r_b          <= 16'd0;
            r_acc        <= 32'd0;
            r_step       <= 2'd0;
            r_issue_done <= 1'b0;
        end else if (w_accept) begin
            r_a          <= bus.a;
            r_b          <= bus.b;
            r_acc        <= 32'd0;
            r_step       <= 2'd0;
            r_issue_done <= 1'b0;
        end else begin
            if (w_issue) begin
                r_step <= r_step + 2'd1;
                if (r_step == 2'd3) begin
                    r_issue_done <= 1'b1;
                end
            end
            if (w_acc_en) begin
                // The full sum fits in 32 bits, so no carry-out is kept.
                r_acc <= r_acc + (32'(w_acc_prod) << STEP_SHIFT[w_acc_step]);
            end
        end
    end

    assign bus.p = r_acc;

endmodule

// File: tb/tb_dadda_mul16_seq.sv
// Directed testbench for dadda_mul16_seq with MUL_PIPE=0 and MUL_PIPE=1 instances.
`timescale 1ns/1ps
module tb_dadda_mul16_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dadda_mul16_seq_if if0 ();
    dadda_mul16_seq_if if1 ();

    dadda_mul16_seq #(.MUL_PIPE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    dadda_mul16_seq #(.MUL_PIPE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MUL_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 5;
`endif

    // One operation on the MUL_PIPE=0 instance; lat=0 means out_valid never arrived.
    task automatic op0(input logic [15:0] x, input logic [15:0] y,
                       output logic [31:0] prod, output int lat);
        int guard;
        @(negedge clk);
        if0.a = x;
        if0.b = y;
        if0.in_valid = 1'b1;
        guard = 0;
        while (!if0.in_ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        lat  = 0;
        prod = 32'hDEADBEEF;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if0.out_valid) begin
                lat  = i;
                prod = if0.p;
                break;
            end
        end
    endtask

    // Same as op0 for the MUL_PIPE=1 instance.
    task automatic op1(input logic [15:0] x, input logic [15:0] y,
                       output logic [31:0] prod, output int lat);
        int guard;
        @(negedge clk);
        if1.a = x;
        if1.b = y;
        if1.in_valid = 1'b1;
        guard = 0;
        while (!if1.in_ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 if1.in_valid = 1'b0;
        lat  = 0;
        prod = 32'hDEADBEEF;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if1.out_valid) begin
                lat  = i;
                prod = if1.p;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({if0.in_ready, if0.out_valid, if0.busy, if0.p} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL reset_pipe0: ready/valid/busy/p = %b%b%b/%h, expected 100/00000000",
                     if0.in_ready, if0.out_valid, if0.busy, if0.p);
        end
        checks++;
        if ({if1.in_ready, if1.out_valid, if1.busy, if1.p} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL reset_pipe1: ready/valid/busy/p = %b%b%b/%h, expected 100/00000000",
                     if1.in_ready, if1.out_valid, if1.busy, if1.p);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] prod;
        int          lat;
        op0(16'h1234, 16'h5678, prod, lat);
        checks++;
        if (prod !== 32'h06260060) begin
            errors++;
            $display("FAIL basic_p: got %h expected 06260060", prod);
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 5", lat);
        end
        @(negedge clk);
        checks++;
        if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_one_cycle: out_valid=%b in_ready=%b expected 0/1",
                     if0.out_valid, if0.in_ready);
        end
    endtask

    task automatic test_max();
        logic [31:0] prod;
        int          lat;
        op0(16'hFFFF, 16'hFFFF, prod, lat);
        checks++;
        if (prod !== 32'hFFFE0001 || lat !== 5) begin
            errors++;
            $display("FAIL max_pipe0: got p=%h lat=%0d expected FFFE0001 lat=5", prod, lat);
        end
    endtask

    task automatic test_pipe();
        logic [31:0] prod;
        int          lat;
        op1(16'hFFFF, 16'hFFFF, prod, lat);
        checks++;
        if (prod !== 32'hFFFE0001 || lat !== 6) begin
            errors++;
            $display("FAIL max_pipe1: got p=%h lat=%0d expected FFFE0001 lat=6", prod, lat);
        end
        op1(16'h1234, 16'h5678, prod, lat);
        checks++;
        if (prod !== 32'h06260060 || lat !== 6) begin
            errors++;
            $display("FAIL basic_pipe1: got p=%h lat=%0d expected 06260060 lat=6", prod, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] prod;
        int          lat;
        if0.out_ready = 1'b0;
        op0(16'h00FF, 16'h0100, prod, lat);
        checks++;
        if (prod !== 32'h0000FF00 || lat !== 5) begin
            errors++;
            $display("FAIL bp_result: got p=%h lat=%0d expected 0000FF00 lat=5", prod, lat);
        end
        if0.a = 16'h0002;
        if0.b = 16'h0001;
        if0.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (if0.out_valid !== 1'b1 || if0.p !== 32'h0000FF00 || if0.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b p=%h ready=%b expected 1/0000FF00/0",
                         i, if0.out_valid, if0.p, if0.in_ready);
            end
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0 || if0.busy !== 1'b0 ||
            if0.p !== 32'h0000FF00) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b busy=%b p=%h expected 1/0/0/0000FF00",
                     if0.in_ready, if0.out_valid, if0.busy, if0.p);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] prod;
        int          lat;
        @(negedge clk);
        if0.a = 16'hAAAA;
        if0.b = 16'h5555;
        if0.in_valid = 1'b1;
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (if0.out_valid !== 1'b0 || if0.p !== 32'd0 || if0.in_ready !== 1'b1 || if0.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b p=%h ready=%b busy=%b expected 0/00000000/1/0",
                     if0.out_valid, if0.p, if0.in_ready, if0.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op0(16'h0003, 16'h0005, prod, lat);
        checks++;
        if (prod !== 32'd15 || lat !== 5) begin
            errors++;
            $display("FAIL after_reset: got p=%h lat=%0d expected 0000000f lat=5", prod, lat);
        end
    endtask

    task automatic test_zero();
        logic [31:0] prod;
        int          lat;
        op0(16'h0000, 16'hABCD, prod, lat);
        checks++;
        if (prod !== 32'd0 || lat !== ZERO_LAT) begin
            errors++;
            $display("FAIL zero_operand: got p=%h lat=%0d expected 00000000 lat=%0d", prod, lat, ZERO_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res [2];
        int          acc_t [2];
        int          nacc;
        int          nres;
        logic        took;
        res[0] = '1; res[1] = '1;
        acc_t[0] = 0; acc_t[1] = 100;
        nacc = 0;
        nres = 0;
        @(negedge clk);
        if0.a = 16'h0002;
        if0.b = 16'h0003;
        if0.in_valid  = 1'b1;
        if0.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            took = if0.in_ready && if0.in_valid && (nacc < 2);
            if (if0.out_valid && nres < 2) begin
                res[nres] = if0.p;
                nres++;
            end
            if (took) begin
                acc_t[nacc] = cyc;
                nacc++;
            end
            if (nres == 2) break;
            @(posedge clk);
            #1;
            if (took && nacc == 1) begin
                if0.a = 16'h8000;
                if0.b = 16'h0002;
            end
            if (took && nacc == 2) if0.in_valid = 1'b0;
            @(negedge clk);
        end
        if0.in_valid = 1'b0;
        checks++;
        if (res[0] !== 32'h00000006) begin
            errors++;
            $display("FAIL b2b_first: got %h expected 00000006", res[0]);
        end
        checks++;
        if (res[1] !== 32'h00010000) begin
            errors++;
            $display("FAIL b2b_second: got %h expected 00010000", res[1]);
        end
        checks++;
        if (acc_t[1] - acc_t[0] !== 6) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles expected 6", acc_t[1] - acc_t[0]);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_max();
        test_pipe();
        test_backpressure();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
